// File: rtl/bcd_down_timer.sv
// Three-digit BCD down-counter/timer (999..000) with parallel load, start/stop
// control, terminal-count pulse and optional auto-reload of the last loaded value.
module bcd_down_timer #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       reset,
  input  logic       clock,
  input  logic       fen,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] ld1,
  input  logic [3:0] ld10,
  input  logic [3:0] ld100,
  output logic [3:0] d1,
  output logic [3:0] d10,
  output logic [3:0] d100,
  output logic       running,
  output logic       done,
  output logic       zero
);

  localparam int unsigned DW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] rl1, rl10, rl100;
  logic [DW-1:0] dec1, dec10, dec100;
  logic [DW-1:0] cl1, cl10, cl100;
  logic          dec_zero;
  logic          rl_zero;

  // Out-of-range load digits saturate at 9 so the digits stay valid BCD.
  function automatic logic [DW-1:0] clamp9(input logic [DW-1:0] v);
    return (v > DW'(9)) ? DW'(9) : v;
  endfunction

  assign cl1   = clamp9(ld1);
  assign cl10  = clamp9(ld10);
  assign cl100 = clamp9(ld100);

  assign zero    = (d1 == '0) && (d10 == '0) && (d100 == '0);
  assign rl_zero = (rl1 == '0) && (rl10 == '0) && (rl100 == '0);

  // Borrow chain: each digit wraps 0 -> 9 only when all lower digits are 0.
  always_comb begin
    dec1   = (d1 == '0) ? DW'(9) : d1 - DW'(1);
    dec10  = d10;
    dec100 = d100;
    if (d1 == '0) begin
      dec10 = (d10 == '0) ? DW'(9) : d10 - DW'(1);
      if (d10 == '0) begin
        dec100 = (d100 == '0) ? DW'(9) : d100 - DW'(1);
      end
    end
    dec_zero = (dec1 == '0) && (dec10 == '0) && (dec100 == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      d1      <= '0;
      d10     <= '0;
      d100    <= '0;
      rl1     <= '0;
      rl10    <= '0;
      rl100   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        d1      <= cl1;
        d10     <= cl10;
        d100    <= cl100;
        rl1     <= cl1;
        rl10    <= cl10;
        rl100   <= cl100;
        state   <= IDLE;
        running <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !zero) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              state   <= IDLE;
              running <= 1'b0;
            end else if (fen) begin
              if (zero) begin
                // Only reachable with auto-reload: restart from the loaded value.
                if (rl_zero) begin
                  state   <= IDLE;
                  running <= 1'b0;
                end else begin
                  d1   <= rl1;
                  d10  <= rl10;
                  d100 <= rl100;
                end
              end else begin
                d1   <= dec1;
                d10  <= dec10;
                d100 <= dec100;
                if (dec_zero) begin
                  done <= 1'b1;
                  if (!AUTO_RELOAD) begin
                    state   <= EXPIRED;
                    running <= 1'b0;
                  end
                end
              end
            end
          end
          EXPIRED: begin
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench: two timers (AUTO_RELOAD 0 and 1) share stimulus and are
// compared every cycle against an integer-valued reference model.
module tb_bcd_down_timer;

  logic       reset, clock, fen, load, start, stop;
  logic [3:0] ld1, ld10, ld100;
  logic [3:0] d1_0, d10_0, d100_0, d1_1, d10_1, d100_1;
  logic       running_0, done_0, zero_0, running_1, done_1, zero_1;

  logic [14:0] obs [2];
  int compared = 0;
  int failed   = 0;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_EXP  = 2;

  int m_val  [2];
  int m_rl   [2];
  int m_st   [2];
  bit m_done [2];

  bcd_down_timer #(.AUTO_RELOAD(1'b0)) dut0 (
    .reset(reset), .clock(clock), .fen(fen), .load(load), .start(start), .stop(stop),
    .ld1(ld1), .ld10(ld10), .ld100(ld100),
    .d1(d1_0), .d10(d10_0), .d100(d100_0),
    .running(running_0), .done(done_0), .zero(zero_0)
  );

  bcd_down_timer #(.AUTO_RELOAD(1'b1)) dut1 (
    .reset(reset), .clock(clock), .fen(fen), .load(load), .start(start), .stop(stop),
    .ld1(ld1), .ld10(ld10), .ld100(ld100),
    .d1(d1_1), .d10(d10_1), .d100(d100_1),
    .running(running_1), .done(done_1), .zero(zero_1)
  );

  assign obs[0] = {d100_0, d10_0, d1_0, running_0, done_0, zero_0};
  assign obs[1] = {d100_1, d10_1, d1_1, running_1, done_1, zero_1};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int clampd(input logic [3:0] v);
    return (v > 4'd9) ? 9 : int'(v);
  endfunction

  function automatic logic [14:0] exp_vec(input int k);
    int v;
    v = m_val[k];
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10),
            (m_st[k] == M_RUN), m_done[k], (v == 0)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0; m_rl[k] = 0; m_st[k] = M_IDLE; m_done[k] = 1'b0;
    end
  endtask

  // Timer behaviour on a plain integer 0..999; called once per rising edge.
  task automatic model_step(input int k, input bit ar);
    m_done[k] = 1'b0;
    if (load) begin
      m_val[k] = clampd(ld100) * 100 + clampd(ld10) * 10 + clampd(ld1);
      m_rl[k]  = m_val[k];
      m_st[k]  = M_IDLE;
    end else if (m_st[k] == M_IDLE) begin
      if (start && m_val[k] != 0) m_st[k] = M_RUN;
    end else if (m_st[k] == M_RUN) begin
      if (stop) m_st[k] = M_IDLE;
      else if (fen) begin
        if (m_val[k] == 0) begin
          if (m_rl[k] == 0) m_st[k] = M_IDLE;
          else m_val[k] = m_rl[k];
        end else begin
          m_val[k] = m_val[k] - 1;
          if (m_val[k] == 0) begin
            m_done[k] = 1'b1;
            if (!ar) m_st[k] = M_EXP;
          end
        end
      end
    end
  endtask

  task automatic tick(input bit l, input bit s, input bit st, input bit f,
                      input logic [3:0] a100, input logic [3:0] a10, input logic [3:0] a1);
    load = l; stop = s; start = st; fen = f;
    ld100 = a100; ld10 = a10; ld1 = a1;
    @(posedge clock);
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (obs[k] !== 15'h0001) begin
        failed++;
        $display("FAIL reset_state dut%0d: got %h want %h", k, obs[k], 15'h0001);
      end
    end
    reset = 1'b1;
    tick(1, 0, 0, 0, 4'd1, 4'd2, 4'd3);
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (obs[k] !== 15'h0001) begin
        failed++;
        $display("FAIL async_reset dut%0d: got %h want %h", k, obs[k], 15'h0001);
      end
    end
    tick(0, 0, 1, 1, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 1, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== exp_vec(k) || obs[k] !== 15'h0001) begin
          failed++;
          $display("FAIL post_reset dut%0d cyc %0d: got %h want %h", k, i, obs[k], 15'h0001);
        end
      end
    end
  endtask

  task automatic test_count();
    tick(1, 0, 0, 0, 4'd1, 4'd0, 4'd2);
    tick(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== exp_vec(k)) begin
          failed++;
          $display("FAIL count102 dut%0d step %0d: got %h want %h", k, i, obs[k], exp_vec(k));
        end
      end
    end
    compared++;
    if ({d100_0, d10_0, d1_0, running_0, done_0} !== {12'h099, 1'b1, 1'b0}) begin
      failed++;
      $display("FAIL count102_final: got %h want %h", {d100_0, d10_0, d1_0, running_0, done_0},
               {12'h099, 1'b1, 1'b0});
    end
  endtask

  task automatic test_expire();
    tick(1, 0, 0, 0, 4'd0, 4'd0, 4'd1);
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    compared++;
    if ({d100_0, d10_0, d1_0, running_0, done_0, zero_0} !== {12'h000, 3'b011}) begin
      failed++;
      $display("FAIL expire_hit: got %h want %h", obs[0], {12'h000, 3'b011});
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, i[0], 1, 1, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== exp_vec(k)) begin
          failed++;
          $display("FAIL expire_hold dut%0d cyc %0d: got %h want %h", k, i, obs[k], exp_vec(k));
        end
      end
    end
    compared++;
    if ({d100_0, d10_0, d1_0, running_0, done_0} !== 14'h0) begin
      failed++;
      $display("FAIL expire_final: got %h want %h", {d100_0, d10_0, d1_0, running_0, done_0}, 14'h0);
    end
  endtask

  task automatic test_zero_clamp();
    tick(1, 0, 0, 0, 4'd0, 4'd0, 4'd0);
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (obs[k] !== 15'h0001) begin
        failed++;
        $display("FAIL zero_start dut%0d: got %h want %h", k, obs[k], 15'h0001);
      end
    end
    tick(1, 0, 0, 0, 4'hA, 4'hF, 4'h3);
    compared++;
    if ({d100_1, d10_1, d1_1} !== 12'h993 || obs[0] !== exp_vec(0)) begin
      failed++;
      $display("FAIL clamp: got %h want %h", {d100_1, d10_1, d1_1}, 12'h993);
    end
    tick(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 0, 1, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== exp_vec(k)) begin
          failed++;
          $display("FAIL clamp_count dut%0d cyc %0d: got %h want %h", k, i, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_stop();
    tick(1, 0, 0, 0, 4'd0, 4'd5, 4'd0);
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    tick(0, 1, 0, 1, 0, 0, 0);
    compared++;
    if ({d100_0, d10_0, d1_0, running_0} !== {12'h049, 1'b0}) begin
      failed++;
      $display("FAIL stop_hold: got %h want %h", {d100_0, d10_0, d1_0, running_0}, {12'h049, 1'b0});
    end
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    compared++;
    if ({d100_1, d10_1, d1_1, running_1} !== {12'h048, 1'b1}) begin
      failed++;
      $display("FAIL stop_resume: got %h want %h", {d100_1, d10_1, d1_1, running_1}, {12'h048, 1'b1});
    end
    tick(1, 1, 1, 1, 4'd7, 4'd3, 4'd1);
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (obs[k] !== exp_vec(k) || obs[k][14:3] !== 12'h731) begin
        failed++;
        $display("FAIL load_priority dut%0d: got %h want %h", k, obs[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_auto_reload();
    int          seq_v [5];
    logic        seq_d [5];
    logic [11:0] want;
    seq_v = '{1, 0, 2, 1, 0};
    seq_d = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tick(1, 0, 0, 0, 4'd0, 4'd0, 4'd2);
    tick(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 1, 0, 0, 0);
      want = {4'd0, 4'd0, 4'(seq_v[i])};
      compared++;
      if ({d100_1, d10_1, d1_1, running_1, done_1} !== {want, 1'b1, seq_d[i]}) begin
        failed++;
        $display("FAIL auto_reload step %0d: got %h want %h", i,
                 {d100_1, d10_1, d1_1, running_1, done_1}, {want, 1'b1, seq_d[i]});
      end
      compared++;
      if (obs[0] !== exp_vec(0)) begin
        failed++;
        $display("FAIL auto_reload_ar0 step %0d: got %h want %h", i, obs[0], exp_vec(0));
      end
    end
  endtask

  task automatic test_random();
    bit l, s, st, f;
    for (int i = 0; i < 2000; i++) begin
      l  = ($urandom_range(0, 15) == 0);
      s  = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 3) != 0);
      tick(l, s, st, f, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs[k] !== exp_vec(k)) begin
          failed++;
          $display("FAIL random dut%0d cyc %0d: got %h want %h", k, i, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0; fen = 1'b0;
    ld1 = '0; ld10 = '0; ld100 = '0;
    model_reset();
    test_reset();
    test_count();
    test_expire();
    test_zero_clamp();
    test_stop();
    test_auto_reload();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Three-digit BCD down-counter/timer, 999..000, with parallel load, start/stop control and terminal-count signalling.
- Decrements once per qualified clock-enable tick (fen).
- Complements the three-digit BCD up-counter chain: same digit format, same enable-tick style, borrow chain instead of carry chain.
- Feeds the same 4-bit-per-digit display/decode path; gives the control FSM a countdown-expired event.

Parameters:
- AUTO_RELOAD, 0, 1 = on reaching 000, reload the last loaded value and keep running; 0 = stop at 000.

Ports:
- reset  input  1  asynchronous, active-low reset
- clock  input  1  rising-edge clock
- fen  input  1  count-tick enable; one decrement per cycle where fen=1 while running
- load  input  1  synchronous parallel load strobe
- start  input  1  begin/resume counting
- stop  input  1  pause counting, hold value
- ld1  input  4  load value, units digit
- ld10  input  4  load value, tens digit
- ld100  input  4  load value, hundreds digit
- d1  output  4  current units digit, BCD
- d10  output  4  current tens digit, BCD
- d100  output  4  current hundreds digit, BCD
- running  output  1  high while FSM in RUN
- done  output  1  one-cycle pulse on reaching 000
- zero  output  1  combinational, high when d100=d10=d1=0

Behaviour:
- Reset (reset=0, asynchronous, active-low; clock clock):
  - d1 = d10 = d100 = 0; reload register = 000; state IDLE; running = 0; done = 0.
  - Reset mid-run aborts immediately; no done pulse.
- Registered state, all updates on the rising clock edge.
- FSM states:
  - IDLE: holding value, not counting.
  - RUN: counting.
  - EXPIRED: reached 000, AUTO_RELOAD=0 only.
- Input priority per cycle: load > stop > start > fen.
- load (any state):
  - Digits <= ld values; reload register <= same values; state <= IDLE; done <= 0.
  - Any load digit >9 is clamped to 9 on load, for both the counter and the reload register.
- stop:
  - In RUN: state <= IDLE, digits held; the fen tick in that cycle is ignored.
  - Elsewhere: no effect.
- start:
  - In IDLE with zero=0: state <= RUN. The first decrement occurs on the first fen after the transition; a fen in the start cycle is ignored.
  - In IDLE with zero=1, or in EXPIRED: ignored.
  - In RUN: no effect.
- Decrement (RUN, fen=1, no load/stop):
  - d1: 0 -> 9 with borrow, else d1-1.
  - d10 decrements only when d1=0; 0 -> 9 with borrow.
  - d100 decrements only when d1=0 and d10=0.
  - Digits never leave 0..9.
- Terminal count, decrement producing 000:
  - AUTO_RELOAD=0: digits <= 000, state <= EXPIRED, done=1 in the next cycle only.
  - AUTO_RELOAD=1: digits <= 000 for this cycle. On the next fen, digits <= reload register and state stays RUN, rather than decrementing below 000. done=1 for one cycle after reaching 000. If the reload register is 000, state <= IDLE instead.
- EXPIRED: held until load (-> IDLE). start, stop and fen are ignored.
- running = (state == RUN), registered.
- done is registered. It is never high for two consecutive cycles and never asserted by load or reset.
- fen held high continuously gives one decrement per clock.

Test Plan:
- Reset low mid-operation -> all digits 0, running=0, done=0 immediately (asynchronous); stays so after release until load.
- Load 1/0/2 (102), start, 3 fen pulses -> d100/d10/d1 = 0/9/9 (099), running=1, done=0 throughout.
- Load 0/0/1, start, 1 fen -> digits 000, state EXPIRED, done=1 for exactly one cycle, running=0; further start/fen leave 000 and done=0.
- Load 0/0/0 then start -> running stays 0, no done. Load 0xA/0xF/0x3 -> digits 9/9/3 (clamped).
- Load 0/5/0 (050), start, fen; stop asserted with fen in the same cycle -> 049 held, running=0. Then start, fen -> 048. Load+stop+fen in one cycle -> load value wins.
- AUTO_RELOAD=1: load 0/0/2 (002), start, fen held high -> sequence 001, 000 (done pulse), 002, 001, 000 (done pulse); running stays 1.
